// File: rtl/write_port_arbiter.sv
// Registered write-port arbiter. The ALU always wins the port; colliding local
// writes are parked in a small FIFO and retired on ALU-idle cycles.
module write_port_arbiter #(
  parameter int unsigned WORD_WIDTH       = 36,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned DEFER_DEPTH      = 4,
  parameter int unsigned DEFER_ADDR_WIDTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ALU_wren,
  input  logic [ADDR_WIDTH-1:0]       ALU_write_addr,
  input  logic [WORD_WIDTH-1:0]       ALU_write_data,
  input  logic                        local_wren,
  input  logic [ADDR_WIDTH-1:0]       local_write_addr,
  input  logic [WORD_WIDTH-1:0]       local_write_data,
  output logic                        local_ready,
  output logic                        wren,
  output logic [ADDR_WIDTH-1:0]       write_addr,
  output logic [WORD_WIDTH-1:0]       write_data,
  output logic [DEFER_ADDR_WIDTH:0]   defer_count,
  output logic                        overflow
);

  localparam int unsigned CNT_W = DEFER_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEFER_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DEFER_ADDR_WIDTH-1:0] PTR_ONE = DEFER_ADDR_WIDTH'(1);

  // Deferral queue storage
  logic                  q_valid [DEFER_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [DEFER_DEPTH];
  logic [WORD_WIDTH-1:0] q_data  [DEFER_DEPTH];

  logic [DEFER_ADDR_WIDTH-1:0] head;
  logic [DEFER_ADDR_WIDTH-1:0] tail;
  logic [CNT_W-1:0]            count;

  logic                  q_empty;
  logic                  q_full;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  issue_upd;
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [WORD_WIDTH-1:0] issue_data;
  logic [CNT_W-1:0]      count_next;
  logic                  kill [DEFER_DEPTH];

  assign q_empty = (count == '0);
  assign q_full  = (count == FULL_CNT);

  // Per-cycle port selection: ALU, then queue head, then bypass
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    drop       = 1'b0;
    issue_upd  = 1'b0;
    issue_en   = 1'b0;
    issue_addr = ALU_write_addr;
    issue_data = ALU_write_data;
    if (ALU_wren) begin
      issue_upd = 1'b1;
      issue_en  = 1'b1;
      if (local_wren) begin
        if (q_full) begin
          drop = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
    end else if (!q_empty) begin
      pop        = 1'b1;
      issue_upd  = 1'b1;
      issue_en   = q_valid[head];
      issue_addr = q_addr[head];
      issue_data = q_data[head];
      push       = local_wren;
    end else if (local_wren) begin
      issue_upd  = 1'b1;
      issue_en   = 1'b1;
      issue_addr = local_write_addr;
      issue_data = local_write_data;
    end
  end

  // Older queued writes to the ALU's address are superseded and must not land
  always_comb begin
    for (int i = 0; i < DEFER_DEPTH; i++) begin
      kill[i] = ALU_wren && q_valid[i] && (q_addr[i] == ALU_write_addr);
    end
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Queue state; the push is applied last so a same-cycle push survives kill/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEFER_DEPTH; i++) begin
        q_valid[i] <= 1'b0;
        q_addr[i]  <= '0;
        q_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEFER_DEPTH; i++) begin
        if (kill[i]) begin
          q_valid[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PTR_ONE;
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        q_addr[tail]  <= local_write_addr;
        q_data[tail]  <= local_write_data;
        tail          <= tail + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // Registered memory port and status
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wren        <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      overflow    <= 1'b0;
      local_ready <= 1'b1;
    end else begin
      wren <= issue_en;
      if (issue_upd) begin
        write_addr <= issue_addr;
        write_data <= issue_data;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      local_ready <= (count_next != FULL_CNT);
    end
  end

  assign defer_count = count;

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed bench for write_port_arbiter: bypass, collision, kill, same-cycle
// survivor, full/overflow with pop+push at full, and reset mid-drain.
module tb_write_port_arbiter;

  localparam int unsigned WW = 36;
  localparam int unsigned AW = 10;

  logic          clock;
  logic          reset;
  logic          ALU_wren;
  logic [AW-1:0] ALU_write_addr;
  logic [WW-1:0] ALU_write_data;
  logic          local_wren;
  logic [AW-1:0] local_write_addr;
  logic [WW-1:0] local_write_data;
  logic          local_ready;
  logic          wren;
  logic [AW-1:0] write_addr;
  logic [WW-1:0] write_data;
  logic [2:0]    defer_count;
  logic          overflow;

  int n_tests;
  int n_fail;

  write_port_arbiter #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEFER_DEPTH(4), .DEFER_ADDR_WIDTH(2)
  ) dut (
    .clock(clock), .reset(reset),
    .ALU_wren(ALU_wren), .ALU_write_addr(ALU_write_addr), .ALU_write_data(ALU_write_data),
    .local_wren(local_wren), .local_write_addr(local_write_addr), .local_write_data(local_write_data),
    .local_ready(local_ready), .wren(wren), .write_addr(write_addr), .write_data(write_data),
    .defer_count(defer_count), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ae, input logic [AW-1:0] aa, input logic [WW-1:0] ad,
                       input logic le, input logic [AW-1:0] la, input logic [WW-1:0] ld);
    ALU_wren = ae; ALU_write_addr = aa; ALU_write_data = ad;
    local_wren = le; local_write_addr = la; local_write_data = ld;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [AW-1:0] a,
                            input logic [WW-1:0] d, input int cnt);
    check({tag, ".wren"}, 64'(wren), 64'(we));
    check({tag, ".addr"}, 64'(write_addr), 64'(a));
    check({tag, ".data"}, 64'(write_data), 64'(d));
    check({tag, ".count"}, 64'(defer_count), 64'(cnt));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    check_port("rst", 1'b0, '0, '0, 0);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.ready", 64'(local_ready), 64'd1);
    reset = 1'b0;

    // Bypass
    drive(1'b0, '0, '0, 1'b1, 10'h005, 36'h123);
    step();
    check_port("byp", 1'b1, 10'h005, 36'h123, 0);

    // Collision then drain
    drive(1'b1, 10'h010, 36'hAAA, 1'b1, 10'h020, 36'hBBB);
    step();
    check_port("col0", 1'b1, 10'h010, 36'hAAA, 1);
    idle();
    step();
    check_port("col1", 1'b1, 10'h020, 36'hBBB, 0);

    // Kill: deferred 0x030 superseded by later ALU write to 0x030
    drive(1'b1, 10'h031, 36'h111, 1'b1, 10'h030, 36'h222);
    step();
    check_port("kill0", 1'b1, 10'h031, 36'h111, 1);
    drive(1'b1, 10'h030, 36'h333, 1'b0, '0, '0);
    step();
    check_port("kill1", 1'b1, 10'h030, 36'h333, 1);
    idle();
    step();
    check_port("kill2", 1'b0, 10'h030, 36'h222, 0);
    step();
    check("kill3.wren", 64'(wren), 64'd0);

    // Same-cycle local write to the ALU's address survives
    drive(1'b1, 10'h040, 36'h444, 1'b1, 10'h040, 36'h555);
    step();
    check_port("same0", 1'b1, 10'h040, 36'h444, 1);
    idle();
    step();
    check_port("same1", 1'b1, 10'h040, 36'h555, 0);

    // Fill queue to DEPTH under continuous ALU traffic
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(32'h100 + i), WW'(32'h1000 + i), 1'b1, AW'(32'h200 + i), WW'(32'h2000 + i));
      step();
      check_port($sformatf("fill%0d", i), 1'b1, AW'(32'h100 + i), WW'(32'h1000 + i), i + 1);
      check($sformatf("fill%0d.ready", i), 64'(local_ready), (i < 3) ? 64'd1 : 64'd0);
    end
    check("fill.ovf", 64'(overflow), 64'd0);
    // Forced local write with a full queue is dropped
    drive(1'b1, 10'h104, 36'h1004, 1'b1, 10'h204, 36'h2004);
    step();
    check_port("ovf", 1'b1, 10'h104, 36'h1004, 4);
    check("ovf.flag", 64'(overflow), 64'd1);
    // Pop and push together at full: count stays 4
    drive(1'b0, '0, '0, 1'b1, 10'h300, 36'h3000);
    step();
    check_port("fullpp", 1'b1, 10'h200, 36'h2000, 4);
    check("fullpp.ready", 64'(local_ready), 64'd0);
    idle();
    for (int i = 1; i < 4; i++) begin
      step();
      check_port($sformatf("drain%0d", i), 1'b1, AW'(32'h200 + i), WW'(32'h2000 + i), 4 - i);
    end
    check("drain.ready", 64'(local_ready), 64'd1);
    step();
    check_port("drain4", 1'b1, 10'h300, 36'h3000, 0);
    check("drain.ovf", 64'(overflow), 64'd1);

    // Reset mid-drain with three queued entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h150 + i), WW'(32'h1500 + i), 1'b1, AW'(32'h250 + i), WW'(32'h2500 + i));
      step();
    end
    check("pre_rst.count", 64'(defer_count), 64'd3);
    idle();
    #2;
    reset = 1'b1;
    #1;
    check_port("arst", 1'b0, '0, '0, 0);
    check("arst.ovf", 64'(overflow), 64'd0);
    check("arst.ready", 64'(local_ready), 64'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_port($sformatf("post_rst%0d", i), 1'b0, '0, '0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
